// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port memory with combinational read and level-sensitive write.
// Sequences one memory access per beat; read beats are returned on a valid/ready stream.
module mem_burst_master #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wr_enable,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_PULSE,
      RD_ADDR,
      RD_RSP,
      DONE
   } state_t;

   localparam int unsigned           DEPTH_U   = DEPTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   dataIn_q, dataIn_d;
   logic                    wrEn_q, wrEn_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rvalid_q, rvalid_d;
   logic                    err_q, err_d;
   logic                    outOfRange;
   logic [ADDR_WIDTH-1:0]   addrNext;

   assign outOfRange = 32'(cmd_addr) >= DEPTH_U;
   assign addrNext   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         dataIn_q <= '0;
         wrEn_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         dataIn_q <= dataIn_d;
         wrEn_q   <= wrEn_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   // Address and write data only move while the write strobe is low or falling,
   // so the level-sensitive memory never sees a glitched address.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      dataIn_d = dataIn_q;
      wrEn_d   = wrEn_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cnt_d = cmd_len;
               if (outOfRange) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  addr_d  = cmd_addr;
                  state_d = cmd_write ? WR_DATA : RD_ADDR;
               end
            end
         end
         WR_DATA: begin
            if (wdata_valid) begin
               dataIn_d = wdata;
               wrEn_d   = 1'b1;
               state_d  = WR_PULSE;
            end
         end
         WR_PULSE: begin
            wrEn_d  = 1'b0;
            addr_d  = addrNext;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? DONE : WR_DATA;
         end
         RD_ADDR: begin
            rdata_d  = mem_data_out;
            rvalid_d = 1'b1;
            state_d  = RD_RSP;
         end
         RD_RSP: begin
            if (rdata_ready) begin
               rvalid_d = 1'b0;
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addrNext;
                  cnt_d   = cnt_q - 1'b1;
                  state_d = RD_ADDR;
               end
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready     = rst_n && (state_q == IDLE);
   assign wdata_ready   = (state_q == WR_DATA);
   assign done          = (state_q == DONE);
   assign err           = err_q;
   assign rdata_valid   = rvalid_q;
   assign rdata         = rdata_q;
   assign mem_addr      = addr_q;
   assign mem_data_in   = dataIn_q;
   assign mem_wr_enable = wrEn_q;

endmodule
